// File: rtl/deal_sequencer.sv
// Baccarat game sequencer: steps the six card-register load strobes through
// the initial deal and the third-card rules, then lights the winner(s).
module deal_sequencer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_P1   = 4'd1,
    S_D1   = 4'd2,
    S_P2   = 4'd3,
    S_D2   = 4'd4,
    S_EVAL = 4'd5,
    S_P3   = 4'd6,
    S_BCHK = 4'd7,
    S_D3   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t state;
  state_t state_nxt;

  // Banker third-card rule. Face cards and tens (10..13) count as zero.
  // Banker totals of 7 and above (including out-of-range values) stand.
  function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] card);
    logic [3:0] v;
    logic       draw;
    v    = (card >= 4'd10) ? 4'd0 : card;
    draw = 1'b0;
    case (d)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  // State register; reset forces S_RST immediately, independent of the clock.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= S_RST;
    else         state <= state_nxt;
  end

  // Next-state: fixed deal order, then natural / player / banker decisions.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_P1;
      S_P1:   state_nxt = S_D1;
      S_D1:   state_nxt = S_P2;
      S_P2:   state_nxt = S_D2;
      S_D2:   state_nxt = S_EVAL;
      S_EVAL: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_nxt = S_DONE;
        else if (pscore <= 4'd5)                  state_nxt = S_P3;
        else if (dscore <= 4'd5)                  state_nxt = S_D3;
        else                                      state_nxt = S_DONE;
      end
      S_P3:   state_nxt = S_BCHK;
      S_BCHK: state_nxt = banker_draws(dscore, pcard3) ? S_D3 : S_DONE;
      S_D3:   state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_RST;
    endcase
  end

  // Moore outputs: one strobe per dealing state, lights only once the hand is over.
  always_comb begin
    load_pcard1      = (state == S_P1);
    load_dcard1      = (state == S_D1);
    load_pcard2      = (state == S_P2);
    load_dcard2      = (state == S_D2);
    load_pcard3      = (state == S_P3);
    load_dcard3      = (state == S_D3);
    player_win_light = (state == S_DONE) && (pscore >= dscore);
    dealer_win_light = (state == S_DONE) && (dscore >= pscore);
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: a per-cycle event model of a hand drives
// the scores like the card registers/scorers would and predicts every output.
module tb_deal_sequencer;

  logic       clk;
  logic       resetb;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int n_cmp  = 0;
  int n_fail = 0;

  // Event codes per cycle: 0 idle, 1 P1, 2 D1, 3 P2, 4 D2, 5 P3, 6 D3, 7 hand over
  logic [2:0] seq [0:12];
  int         cyc;
  logic       checking;
  string      cur_name;

  deal_sequencer dut (
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banker rule as a lower bound on v: totals 4,5,6 need v in [2*(d-3), 7].
  function automatic logic model_draw(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return (v != 8);
    if (d >= 7) return 1'b0;
    return (v >= 2 * (d - 3)) && (v <= 7);
  endfunction

  // Build the expected event list of a hand from its evaluation-time scores.
  task automatic build(input int ep, input int ed, input int pc3);
    int k;
    int v;
    seq[0] = 3'd0;
    seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3; seq[4] = 3'd4;
    seq[5] = 3'd0;
    k = 6;
    if (ep >= 8 || ed >= 8) begin
      k = 6;
    end else if (ep <= 5) begin
      seq[6] = 3'd5;
      seq[7] = 3'd0;
      k = 8;
      v = (pc3 >= 10) ? 0 : pc3;
      if (model_draw(ed, v)) begin
        seq[8] = 3'd6;
        k = 9;
      end
    end else if (ed <= 5) begin
      seq[6] = 3'd6;
      k = 7;
    end
    for (int i = k; i <= 12; i++) seq[i] = 3'd7;
  endtask

  function automatic logic [7:0] expect_out(input logic [2:0] code, input logic [3:0] p, input logic [3:0] d);
    logic [7:0] e;
    e = 8'b0;
    case (code)
      3'd1: e[5] = 1'b1;
      3'd2: e[4] = 1'b1;
      3'd3: e[3] = 1'b1;
      3'd4: e[2] = 1'b1;
      3'd5: e[1] = 1'b1;
      3'd6: e[0] = 1'b1;
      3'd7: begin e[7] = (p >= d); e[6] = (d >= p); end
      default: e = 8'b0;
    endcase
    return e;
  endfunction

  function automatic logic [7:0] dut_out();
    return {player_win_light, dealer_win_light, load_pcard1, load_dcard1,
            load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  endfunction

  // Compare process: every negedge while a hand is running.
  always @(negedge clk) begin
    if (checking) begin
      logic [7:0] e;
      e = expect_out(seq[cyc], pscore, dscore);
      n_cmp++;
      if (dut_out() !== e) begin
        n_fail++;
        $display("FAIL %s cyc%0d outputs got=%b exp=%b", cur_name, cyc, dut_out(), e);
      end
    end
  end

  task automatic pin(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Run a full hand: eval scores until a third card is loaded, then final scores.
  task automatic run_hand(input string name, input int ep, input int ed, input int pc3,
                          input int fp, input int fd);
    logic pdrawn, ddrawn;
    build(ep, ed, pc3);
    cur_name = name;
    resetb   = 1'b0;
    pscore   = 4'(ep);
    dscore   = 4'(ed);
    pcard3   = 4'(pc3);
    cyc      = 0;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      pdrawn = 1'b0;
      ddrawn = 1'b0;
      for (int k = 1; k < c; k++) begin
        if (seq[k] == 3'd5) pdrawn = 1'b1;
        if (seq[k] == 3'd6) ddrawn = 1'b1;
      end
      pscore = pdrawn ? 4'(fp) : 4'(ep);
      dscore = ddrawn ? 4'(fd) : 4'(ed);
      cyc    = c;
    end
    @(negedge clk);
    #1 checking = 1'b0;
  endtask

  task automatic pin_lights(input string name, input logic [1:0] exp);
    n_cmp++;
    if ({player_win_light, dealer_win_light} !== exp) begin
      n_fail++;
      $display("FAIL %s lights got=%b exp=%b", name, {player_win_light, dealer_win_light}, exp);
    end
  endtask

  initial begin
    resetb = 1'b0; pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    checking = 1'b0; cyc = 0; cur_name = "idle";

    // Hand-computed pins on the model itself
    build(8, 3, 0);  pin("model_nat_done6", seq[6], 7);  pin("model_nat_c5", seq[5], 0);
    build(4, 5, 6);  pin("model_pd_p3", seq[6], 5);      pin("model_pd_d3", seq[8], 6);
                     pin("model_pd_done", seq[9], 7);
    build(6, 5, 0);  pin("model_sd_d3", seq[6], 6);      pin("model_sd_done", seq[7], 7);
    build(2, 3, 8);  pin("model_d3v8", seq[8], 7);
    build(2, 3, 12); pin("model_d3v0", seq[8], 6);
    build(3, 6, 5);  pin("model_d6v5", seq[8], 7);

    run_hand("natural", 8, 3, 0, 8, 3);        pin_lights("natural_lights", 2'b10);
    run_hand("both_draw", 4, 5, 6, 0, 7);      pin_lights("both_draw_lights", 2'b01);
    run_hand("pstand_bdraw", 6, 5, 0, 6, 6);   pin_lights("pstand_bdraw_lights", 2'b11);
    run_hand("d3_v8", 2, 3, 8, 0, 3);          pin_lights("d3_v8_lights", 2'b01);
    run_hand("d3_face", 2, 3, 12, 2, 9);
    run_hand("d6_v5", 3, 6, 5, 8, 6);
    run_hand("d7_v7", 1, 7, 7, 8, 7);
    run_hand("both_stand", 7, 7, 0, 7, 7);     pin_lights("both_stand_lights", 2'b11);
    run_hand("oor_natural", 12, 0, 0, 12, 0);
    run_hand("d4_v1", 5, 4, 1, 6, 4);
    run_hand("d5_v4", 1, 5, 4, 5, 2);

    // Reset asserted mid-cycle in S_D1: strobe must drop without a clock edge.
    cur_name = "midreset";
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    pin("midreset_d1_high", load_dcard1, 1);
    resetb = 1'b0;
    #2;
    pin("midreset_d1_dropped", load_dcard1, 0);
    pin("midreset_all_zero", dut_out(), 0);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    pin("midreset_restart_p1", dut_out(), 8'b0010_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
